vga_timing_gen: RTL and testbench

//  Upstream/downstream VGA stage around the background and object draw path.
//  - Generates 640x480@60Hz raster counters (pixelX/pixelY) that feed back_ground_draw and the object drawers.
//  - Takes the final 8-bit RRRGGGBB pixel back from the draw/mux chain and expands it to 8:8:8.
//  - Drives the DAC-facing RGB, HS, VS and blank outputs, delay-aligned to the draw pipeline latency.

---
 rtl/vga_timing_gen.sv | 164 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel counters, pipeline-aligned sync/blank and RRRGGGBB -> 8:8:8 expansion.
// Optional build macro VGA_TEST_PATTERN_EN replaces RGBIn with eight 80-pixel colour bars.
`timescale 1ns/1ps
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FPORCH  = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BPORCH  = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FPORCH  = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BPORCH  = 33,
   parameter int PIPE_DLY  = 2
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic [7:0]  RGBIn,
   output logic [10:0] pixelX,
   output logic [10:0] pixelY,
   output logic        startOfFrame,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        hsync,
   output logic        vsync,
   output logic        blankN
);

   localparam int H_TOTAL = H_VISIBLE + H_FPORCH + H_SYNC + H_BPORCH;
   localparam int V_TOTAL = V_VISIBLE + V_FPORCH + V_SYNC + V_BPORCH;
   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
   localparam logic [10:0] HS_BEGIN = 11'(H_VISIBLE + H_FPORCH);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FPORCH + H_SYNC);
   localparam logic [10:0] VS_BEGIN = 11'(V_VISIBLE + V_FPORCH);
   localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FPORCH + V_SYNC);

   logic [10:0]         xCnt_q, xCnt_d, yCnt_q, yCnt_d;
   logic                started_q, sof_q, sof_d;
   logic                visRaw, hsRaw, vsRaw, visIn, hsIn, vsIn;
   logic [PIPE_DLY-1:0] visPipe_q, hsPipe_q, vsPipe_q;
   logic                visDly;
   logic [7:0]          pix8;
   logic [7:0]          red_d, green_d, blue_d, red_q, green_q, blue_q;
   logic                hsync_q, vsync_q, blank_q;

   // The first clock after reset holds 0/0 so that clock carries the start-of-frame pulse.
   always_comb begin
      xCnt_d = xCnt_q;
      yCnt_d = yCnt_q;
      sof_d  = !started_q || (xCnt_q == H_LAST && yCnt_q == V_LAST);
      if (started_q) begin
         if (xCnt_q == H_LAST) begin
            xCnt_d = '0;
            yCnt_d = (yCnt_q == V_LAST) ? '0 : yCnt_q + 11'd1;
         end else begin
            xCnt_d = xCnt_q + 11'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         xCnt_q    <= '0;
         yCnt_q    <= '0;
         sof_q     <= 1'b0;
         started_q <= 1'b0;
      end else begin
         xCnt_q    <= xCnt_d;
         yCnt_q    <= yCnt_d;
         sof_q     <= sof_d;
         started_q <= 1'b1;
      end
   end

   assign visRaw = (xCnt_q < H_VIS) && (yCnt_q < V_VIS);
   assign hsRaw  = !((xCnt_q >= HS_BEGIN) && (xCnt_q < HS_END));
   assign vsRaw  = !((yCnt_q >= VS_BEGIN) && (yCnt_q < VS_END));
   assign visIn  = started_q && visRaw;
   assign hsIn   = !started_q || hsRaw;
   assign vsIn   = !started_q || vsRaw;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         visPipe_q <= '0;
         hsPipe_q  <= '1;
         vsPipe_q  <= '1;
      end else begin
         visPipe_q[0] <= visIn;
         hsPipe_q[0]  <= hsIn;
         vsPipe_q[0]  <= vsIn;
         for (int i = 1; i < PIPE_DLY; i++) begin
            visPipe_q[i] <= visPipe_q[i-1];
            hsPipe_q[i]  <= hsPipe_q[i-1];
            vsPipe_q[i]  <= vsPipe_q[i-1];
         end
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   logic [10:0] xPipe_q [PIPE_DLY];
   logic [2:0]  barIdx;
   logic        unusedRgb;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < PIPE_DLY; i++) xPipe_q[i] <= '0;
      end else begin
         xPipe_q[0] <= xCnt_q;
         for (int i = 1; i < PIPE_DLY; i++) xPipe_q[i] <= xPipe_q[i-1];
      end
   end

   assign barIdx    = 3'(xPipe_q[PIPE_DLY-1] / 11'd80);
   assign pix8      = {{3{barIdx[2]}}, {3{barIdx[1]}}, {2{barIdx[0]}}};
   assign unusedRgb = ^RGBIn;
`else
   assign pix8 = RGBIn;
`endif

   assign visDly = visPipe_q[PIPE_DLY-1];

   always_comb begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      if (visDly) begin
         red_d   = {pix8[7:5], pix8[7:5], pix8[7:6]};
         green_d = {pix8[4:2], pix8[4:2], pix8[4:3]};
         blue_d  = {pix8[1:0], pix8[1:0], pix8[1:0], pix8[1:0]};
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         blank_q <= 1'b0;
      end else begin
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
         hsync_q <= hsPipe_q[PIPE_DLY-1];
         vsync_q <= vsPipe_q[PIPE_DLY-1];
         blank_q <= visDly;
      end
   end

   assign pixelX       = xCnt_q;
   assign pixelY       = yCnt_q;
   assign startOfFrame = sof_q;
   assign red          = red_q;
   assign green        = green_q;
   assign blue         = blue_q;
   assign hsync        = hsync_q;
   assign vsync        = vsync_q;
   assign blankN       = blank_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line-level timing and colour, and a
// shrunken-geometry instance so whole frames (vsync, frame wrap) fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic [7:0]  RGBIn = 8'h00;

   logic [10:0] pxA, pyA, pxB, pyB;
   logic        sofA, hsA, vsA, blA, sofB, hsB, vsB, blB;
   logic [7:0]  rA, gA, bA, rB, gB, bB;
   logic [49:0] obsA, obsB;

   int errors = 0;
   int checks = 0;
   int eCnt   = 0;
   logic [7:0] hist [0:65535];

   always #5 clk = ~clk;

   vga_timing_gen dutA (
      .clk(clk), .resetN(resetN), .RGBIn(RGBIn),
      .pixelX(pxA), .pixelY(pyA), .startOfFrame(sofA),
      .red(rA), .green(gA), .blue(bA),
      .hsync(hsA), .vsync(vsA), .blankN(blA)
   );

   vga_timing_gen #(
      .H_VISIBLE(40), .H_FPORCH(4), .H_SYNC(6), .H_BPORCH(5),
      .V_VISIBLE(12), .V_FPORCH(2), .V_SYNC(2), .V_BPORCH(3),
      .PIPE_DLY(3)
   ) dutB (
      .clk(clk), .resetN(resetN), .RGBIn(RGBIn),
      .pixelX(pxB), .pixelY(pyB), .startOfFrame(sofB),
      .red(rB), .green(gB), .blue(bB),
      .hsync(hsB), .vsync(vsB), .blankN(blB)
   );

   assign obsA = {pxA, pyA, sofA, rA, gA, bA, hsA, vsA, blA};
   assign obsB = {pxB, pyB, sofB, rB, gB, bB, hsB, vsB, blB};

   // Colour a visible pixel should show: replicated 3/3/2-bit fields, or the bar pattern.
   function automatic logic [23:0] colourOf(logic [7:0] rgb, int x);
      int r3, g3, b2, k;
      k  = x / 80;
`ifdef VGA_TEST_PATTERN_EN
      r3 = ((k / 4) % 2 == 1) ? 7 : 0;
      g3 = ((k / 2) % 2 == 1) ? 7 : 0;
      b2 = (k % 2 == 1) ? 3 : 0;
`else
      r3 = int'(rgb[7:5]);
      g3 = int'(rgb[4:2]);
      b2 = int'(rgb[1:0]) + 0 * k;
`endif
      return {8'((r3 * 73) >> 1), 8'((g3 * 73) >> 1), 8'(b2 * 85)};
   endfunction

   // Expected pins e clocks after reset release; the coordinate at the pins lags the counters by p+1.
   function automatic logic [49:0] modelPins(int e, int hV, int hF, int hS, int hB,
                                             int vV, int vF, int vS, int vB, int p);
      int hT, vT, n, m, mx, my;
      logic [10:0] x, y;
      logic sof, vis, hs, vs;
      logic [23:0] c;
      hT = hV + hF + hS + hB;
      vT = vV + vF + vS + vB;
      x = '0; y = '0; sof = 1'b0;
      if (e >= 1) begin
         n   = e - 1;
         x   = 11'(n % hT);
         y   = 11'((n / hT) % vT);
         sof = (n % (hT * vT)) == 0;
      end
      m = e - p - 2;
      if (m < 0) return {x, y, sof, 24'h0, 1'b1, 1'b1, 1'b0};
      mx  = m % hT;
      my  = (m / hT) % vT;
      vis = (mx < hV) && (my < vV);
      hs  = !((mx >= hV + hF) && (mx < hV + hF + hS));
      vs  = !((my >= vV + vF) && (my < vV + vF + vS));
      c   = vis ? colourOf(hist[e-1], mx) : 24'h0;
      return {x, y, sof, c, hs, vs, vis};
   endfunction

   function automatic logic [49:0] modelA(int e);
      return modelPins(e, 640, 16, 96, 48, 480, 10, 2, 33, 2);
   endfunction

   function automatic logic [49:0] modelB(int e);
      return modelPins(e, 40, 4, 6, 5, 12, 2, 2, 3, 3);
   endfunction

   task automatic applyReset(input logic [7:0] rgb);
      resetN = 1'b0;
      RGBIn  = rgb;
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetN  = 1'b1;
      eCnt    = 0;
      hist[0] = RGBIn;
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      RGBIn  = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      eCnt = 0;
      checks++;
      if (obsA !== modelA(0)) begin errors++; $display("[TB] FAIL resetA obs=%h exp=%h", obsA, modelA(0)); end
      checks++;
      if (obsB !== modelB(0)) begin errors++; $display("[TB] FAIL resetB obs=%h exp=%h", obsB, modelB(0)); end
      checks++;
      if ({hsA, vsA, blA, sofA, rA} !== 12'b1100_0000_0000) begin
         errors++; $display("[TB] FAIL resetPins obs=%b exp=110000000000", {hsA, vsA, blA, sofA, rA});
      end
      @(negedge clk);
      resetN  = 1'b1;
      hist[0] = RGBIn;
      for (int i = 0; i < 810; i++) begin
         @(posedge clk); eCnt++; #1;
         checks++;
         if (obsA !== modelA(eCnt)) begin errors++; $display("[TB] FAIL modelA e=%0d obs=%h exp=%h", eCnt, obsA, modelA(eCnt)); end
         checks++;
         if (obsB !== modelB(eCnt)) begin errors++; $display("[TB] FAIL modelB e=%0d obs=%h exp=%h", eCnt, obsB, modelB(eCnt)); end
         if (eCnt == 1) begin
            checks++;
            if ({pxA, pyA, sofA} !== {11'd0, 11'd0, 1'b1}) begin
               errors++; $display("[TB] FAIL firstEdge obs=%0d/%0d/%0d exp=0/0/1", pxA, pyA, sofA);
            end
         end
         if (eCnt == 800) begin
            checks++;
            if (pxA !== 11'd799) begin errors++; $display("[TB] FAIL xAt799 obs=%0d exp=799", pxA); end
         end
         if (eCnt == 801) begin
            checks++;
            if ({pxA, pyA, sofA} !== {11'd0, 11'd1, 1'b0}) begin
               errors++; $display("[TB] FAIL xWrap obs=%0d/%0d/%0d exp=0/1/0", pxA, pyA, sofA);
            end
         end
         RGBIn = 8'($urandom); hist[eCnt] = RGBIn;
      end
   endtask

   task automatic test_line_timing();
      int lineStart, firstLow, lowCount;
      logic prevHs;
      lineStart = -1; firstLow = -1; lowCount = 0; prevHs = 1'b1;
      applyReset(8'($urandom));
      for (int i = 0; i < 1700; i++) begin
         @(posedge clk); eCnt++; #1;
         checks++;
         if (obsA !== modelA(eCnt)) begin errors++; $display("[TB] FAIL modelA e=%0d obs=%h exp=%h", eCnt, obsA, modelA(eCnt)); end
         if (lineStart < 0 && eCnt > 1 && pxA == 11'd0) lineStart = eCnt;
         if (lineStart >= 0 && eCnt > lineStart && eCnt <= lineStart + 800) begin
            if (hsA == 1'b0) lowCount++;
            if (hsA == 1'b0 && prevHs == 1'b1 && firstLow < 0) firstLow = eCnt;
         end
         prevHs = hsA;
         RGBIn = 8'($urandom); hist[eCnt] = RGBIn;
      end
      checks++;
      if (firstLow - lineStart != 659) begin
         errors++; $display("[TB] FAIL hsyncOffset obs=%0d exp=659", firstLow - lineStart);
      end
      checks++;
      if (lowCount != 96) begin errors++; $display("[TB] FAIL hsyncWidth obs=%0d exp=96", lowCount); end
   endtask

   task automatic test_colour();
      applyReset(8'hFF);
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); eCnt++; #1;
         checks++;
         if (obsA !== modelA(eCnt)) begin errors++; $display("[TB] FAIL modelA e=%0d obs=%h exp=%h", eCnt, obsA, modelA(eCnt)); end
`ifdef VGA_TEST_PATTERN_EN
         if (eCnt == 44) begin
            checks++;
            if ({rA, gA, bA, blA} !== {24'h000000, 1'b1}) begin errors++; $display("[TB] FAIL bar0 obs=%h exp=0000001", {rA, gA, bA, blA}); end
         end
         if (eCnt == 104) begin
            checks++;
            if ({rA, gA, bA} !== 24'h0000FF) begin errors++; $display("[TB] FAIL bar1 obs=%h exp=0000ff", {rA, gA, bA}); end
         end
         if (eCnt == 204) begin
            checks++;
            if ({rA, gA, bA} !== 24'h00FF00) begin errors++; $display("[TB] FAIL bar2 obs=%h exp=00ff00", {rA, gA, bA}); end
         end
         if (eCnt == 604) begin
            checks++;
            if ({rA, gA, bA} !== 24'hFFFFFF) begin errors++; $display("[TB] FAIL bar7 obs=%h exp=ffffff", {rA, gA, bA}); end
         end
`else
         if (eCnt == 104 || eCnt == 643) begin
            checks++;
            if ({rA, gA, bA, blA} !== {24'hFFFFFF, 1'b1}) begin errors++; $display("[TB] FAIL whiteFF e=%0d obs=%h exp=ffffff1", eCnt, {rA, gA, bA, blA}); end
         end
         if (eCnt == 904) begin
            checks++;
            if ({rA, gA, bA} !== 24'h49DBAA) begin errors++; $display("[TB] FAIL expand5A obs=%h exp=49dbaa", {rA, gA, bA}); end
         end
`endif
         if (eCnt == 644) begin
            checks++;
            if ({rA, gA, bA, blA} !== 25'h0) begin errors++; $display("[TB] FAIL porchBlack obs=%h exp=0000000", {rA, gA, bA, blA}); end
         end
         RGBIn = (eCnt < 850) ? 8'hFF : 8'b010_110_10; hist[eCnt] = RGBIn;
      end
   endtask

   task automatic test_frames();
      int sofCount, runs, runLen, badRuns, maxX, maxY;
      sofCount = 0; runs = 0; runLen = 0; badRuns = 0; maxX = 0; maxY = 0;
      applyReset(8'($urandom));
      for (int i = 0; i < 3 * 1045; i++) begin
         @(posedge clk); eCnt++; #1;
         checks++;
         if (obsB !== modelB(eCnt)) begin errors++; $display("[TB] FAIL modelB e=%0d obs=%h exp=%h", eCnt, obsB, modelB(eCnt)); end
         if (sofB) sofCount++;
         if (int'(pxB) > maxX) maxX = int'(pxB);
         if (int'(pyB) > maxY) maxY = int'(pyB);
         if (!vsB) runLen++;
         else if (runLen > 0) begin
            runs++;
            if (runLen != 110) badRuns++;
            runLen = 0;
         end
         RGBIn = 8'($urandom); hist[eCnt] = RGBIn;
      end
      checks++;
      if (sofCount != 3) begin errors++; $display("[TB] FAIL sofCount obs=%0d exp=3", sofCount); end
      checks++;
      if (runs != 3 || badRuns != 0) begin errors++; $display("[TB] FAIL vsyncRuns obs=%0d/%0d exp=3/0", runs, badRuns); end
      checks++;
      if (maxX != 54 || maxY != 18) begin errors++; $display("[TB] FAIL counterMax obs=%0d/%0d exp=54/18", maxX, maxY); end
   endtask

   task automatic test_mid_reset();
      applyReset(8'hFF);
      for (int i = 0; i < 1101; i++) begin
         @(posedge clk); eCnt++; #1;
         checks++;
         if (obsA !== modelA(eCnt)) begin errors++; $display("[TB] FAIL modelA e=%0d obs=%h exp=%h", eCnt, obsA, modelA(eCnt)); end
         RGBIn = 8'hFF; hist[eCnt] = RGBIn;
      end
      checks++;
      if ({pxA, pyA, rA} !== {11'd300, 11'd1, 8'hFF}) begin
         errors++; $display("[TB] FAIL preReset obs=%0d/%0d/%h exp=300/1/ff", pxA, pyA, rA);
      end
      resetN = 1'b0;
      #1;
      eCnt = 0;
      checks++;
      if (obsA !== modelA(0)) begin errors++; $display("[TB] FAIL midResetA obs=%h exp=%h", obsA, modelA(0)); end
      checks++;
      if (obsB !== modelB(0)) begin errors++; $display("[TB] FAIL midResetB obs=%h exp=%h", obsB, modelB(0)); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetN  = 1'b1;
      hist[0] = RGBIn;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); eCnt++; #1;
         checks++;
         if (obsA !== modelA(eCnt)) begin errors++; $display("[TB] FAIL restartA e=%0d obs=%h exp=%h", eCnt, obsA, modelA(eCnt)); end
         if (eCnt == 1) begin
            checks++;
            if ({pxA, pyA, sofA} !== {11'd0, 11'd0, 1'b1}) begin
               errors++; $display("[TB] FAIL restartSof obs=%0d/%0d/%0d exp=0/0/1", pxA, pyA, sofA);
            end
         end
         RGBIn = 8'($urandom); hist[eCnt] = RGBIn;
      end
   endtask

   initial begin
      test_reset();
      test_line_timing();
      test_colour();
      test_frames();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog obs=timeout exp=finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
